// File: rtl/data_bus_pkg.sv
// data_bus_pkg: shared memory-map constants for the data bus.
//   MMIO_BIT        word-address bit that selects MMIO over RAM
//   MMIO_*          register select values (word address [1:0])
//   STAT_*          bit positions inside the UART status register
//   uart_state_t    UART transmitter FSM encodings
//   merge_lanes     byte-lane merge used by masked register stores
package data_bus_pkg;

  localparam int MMIO_BIT = 29;

  localparam logic [1:0] MMIO_LED       = 2'd0;
  localparam logic [1:0] MMIO_CYCLE     = 2'd1;
  localparam logic [1:0] MMIO_UART_DATA = 2'd2;
  localparam logic [1:0] MMIO_UART_STAT = 2'd3;

  localparam int STAT_FULL  = 0;
  localparam int STAT_EMPTY = 1;
  localparam int STAT_BUSY  = 2;
  localparam int STAT_OVF   = 3;

  typedef enum logic [1:0] {
    UART_IDLE  = 2'd0,
    UART_START = 2'd1,
    UART_DATA  = 2'd2,
    UART_STOP  = 2'd3
  } uart_state_t;

  function automatic logic [31:0] merge_lanes(input logic [31:0] old_word,
                                              input logic [31:0] new_word,
                                              input logic [3:0]  mask);
    logic [31:0] merged;
    merged = old_word;
    for (int k = 0; k < 4; k++) begin
      if (mask[k]) merged[8*k +: 8] = new_word[8*k +: 8];
    end
    return merged;
  endfunction

endpackage

// File: rtl/data_bus_uart_tx.sv
// uart_tx: byte FIFO feeding an 8N1 serial transmitter.
//   clk, rst_n     clock / async active-low reset
//   i_push, i_data push one byte into the FIFO
//   o_full/o_empty FIFO status
//   o_busy         transmitter FSM not idle
//   o_overflow     sticky: a push was dropped because the FIFO was full
//   i_clr_ovf      clears o_overflow (a simultaneous drop wins)
//   o_tx           serial line, idle high
//
// state      | meaning
// UART_IDLE  | line high; pops the FIFO head when data is waiting
// UART_START | start bit (low) for BAUD_DIV cycles
// UART_DATA  | 8 data bits LSB first, BAUD_DIV cycles each
// UART_STOP  | stop bit (high) for BAUD_DIV cycles
module uart_tx
  import data_bus_pkg::*;
#(
  parameter int FIFO_DEPTH = 4,
  parameter int BAUD_DIV   = 434
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       i_push,
  input  logic [7:0] i_data,
  output logic       o_full,
  output logic       o_empty,
  output logic       o_busy,
  output logic       o_overflow,
  input  logic       i_clr_ovf,
  output logic       o_tx
);

  localparam int PW      = $clog2(FIFO_DEPTH);
  localparam int BW      = (BAUD_DIV > 1) ? $clog2(BAUD_DIV) : 1;
  localparam int BAUD_M1 = BAUD_DIV - 1;
  localparam logic [BW-1:0] BAUD_LAST  = BAUD_M1[BW-1:0];
  localparam logic [PW:0]   FULL_COUNT = FIFO_DEPTH[PW:0];

  logic [7:0]    fifo_mem [FIFO_DEPTH];
  logic [PW-1:0] wr_ptr, rd_ptr;
  logic [PW:0]   count;
  uart_state_t   state;
  logic [BW-1:0] baud_cnt;
  logic [2:0]    bit_cnt;
  logic [7:0]    shift;
  logic          pop, push_ok;

  assign o_full  = (count == FULL_COUNT);
  assign o_empty = (count == '0);
  assign o_busy  = (state != UART_IDLE);
  assign pop     = (state == UART_IDLE) && !o_empty;
  // A pop in the same cycle frees a slot, so a push into a full FIFO still lands.
  assign push_ok = i_push && (!o_full || pop);

  always_ff @(posedge clk) begin
    if (push_ok) fifo_mem[wr_ptr] <= i_data;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      count      <= '0;
      o_overflow <= 1'b0;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + 1'b1;
      if (pop)     rd_ptr <= rd_ptr + 1'b1;
      if (push_ok && !pop)      count <= count + 1'b1;
      else if (!push_ok && pop) count <= count - 1'b1;
      if (i_push && !push_ok) o_overflow <= 1'b1;
      else if (i_clr_ovf)     o_overflow <= 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= UART_IDLE;
      baud_cnt <= '0;
      bit_cnt  <= '0;
      shift    <= '0;
      o_tx     <= 1'b1;
    end else begin
      case (state)
        UART_IDLE: begin
          if (pop) begin
            shift    <= fifo_mem[rd_ptr];
            baud_cnt <= BAUD_LAST;
            o_tx     <= 1'b0;
            state    <= UART_START;
          end
        end
        UART_START: begin
          if (baud_cnt == '0) begin
            baud_cnt <= BAUD_LAST;
            bit_cnt  <= '0;
            o_tx     <= shift[0];
            shift    <= {1'b0, shift[7:1]};
            state    <= UART_DATA;
          end else begin
            baud_cnt <= baud_cnt - 1'b1;
          end
        end
        UART_DATA: begin
          if (baud_cnt == '0) begin
            baud_cnt <= BAUD_LAST;
            bit_cnt  <= bit_cnt + 1'b1;
            if (bit_cnt == 3'd7) begin
              o_tx  <= 1'b1;
              state <= UART_STOP;
            end else begin
              o_tx  <= shift[0];
              shift <= {1'b0, shift[7:1]};
            end
          end else begin
            baud_cnt <= baud_cnt - 1'b1;
          end
        end
        UART_STOP: begin
          if (baud_cnt == '0) state <= UART_IDLE;
          else                baud_cnt <= baud_cnt - 1'b1;
        end
      endcase
    end
  end

endmodule

// File: rtl/data_bus.sv
// data_bus: load/store target for the core's data port.
//   clk, rst_n   clock / async active-low reset
//   i_mem_addr   word address; bit 29 selects MMIO, else RAM (index wraps)
//   i_mem_data   lane-aligned store data
//   i_mem_we     store strobe (load when low)
//   i_mem_mask   byte-lane enables for stores
//   o_mem_data   read data, registered: valid the cycle after the address
//   o_uart_tx    UART serial output
//   o_leds       LED register
module data_bus
  import data_bus_pkg::*;
#(
  parameter int RAM_WORDS  = 1024,
  parameter int FIFO_DEPTH = 4,
  parameter int BAUD_DIV   = 434
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [29:0] i_mem_addr,
  input  logic [31:0] i_mem_data,
  input  logic        i_mem_we,
  input  logic [3:0]  i_mem_mask,
  output logic [31:0] o_mem_data,
  output logic        o_uart_tx,
  output logic [7:0]  o_leds
);

  localparam int AW = $clog2(RAM_WORDS);

  logic [31:0]   ram [RAM_WORDS];
  logic [31:0]   cycle_cnt;
  logic [31:0]   rd_word;
  logic          is_mmio, mmio_we;
  logic [1:0]    reg_sel;
  logic [AW-1:0] ram_idx;
  logic          uart_full, uart_empty, uart_busy, uart_ovf;
  logic          uart_push, uart_clr_ovf;
  logic          unused_addr;

  assign is_mmio      = i_mem_addr[MMIO_BIT];
  assign reg_sel      = i_mem_addr[1:0];
  assign ram_idx      = i_mem_addr[AW-1:0];
  assign mmio_we      = is_mmio && i_mem_we;
  assign unused_addr  = ^i_mem_addr[MMIO_BIT-1:AW];
  assign uart_push    = mmio_we && (reg_sel == MMIO_UART_DATA) && i_mem_mask[0];
  assign uart_clr_ovf = mmio_we && (reg_sel == MMIO_UART_STAT) && i_mem_mask[0] && i_mem_data[3];

  // Read mux sees pre-edge state, so a store returns the old contents.
  always_comb begin
    rd_word = '0;
    if (!is_mmio) begin
      rd_word = ram[ram_idx];
    end else begin
      case (reg_sel)
        MMIO_LED:   rd_word = {24'h0, o_leds};
        // The counter steps at the request edge; report the value it takes there.
        MMIO_CYCLE: rd_word = cycle_cnt + 32'd1;
        MMIO_UART_STAT: begin
          rd_word[STAT_FULL]  = uart_full;
          rd_word[STAT_EMPTY] = uart_empty;
          rd_word[STAT_BUSY]  = uart_busy;
          rd_word[STAT_OVF]   = uart_ovf;
        end
        default: rd_word = '0;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (i_mem_we && !is_mmio) begin
      for (int k = 0; k < 4; k++) begin
        if (i_mem_mask[k]) ram[ram_idx][8*k +: 8] <= i_mem_data[8*k +: 8];
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      o_mem_data <= '0;
      o_leds     <= '0;
      cycle_cnt  <= '0;
    end else begin
      o_mem_data <= rd_word;
      if (mmio_we && (reg_sel == MMIO_LED) && i_mem_mask[0]) o_leds <= i_mem_data[7:0];
      if (mmio_we && (reg_sel == MMIO_CYCLE))
        cycle_cnt <= merge_lanes(cycle_cnt, i_mem_data, i_mem_mask);
      else
        cycle_cnt <= cycle_cnt + 32'd1;
    end
  end

  uart_tx #(
    .FIFO_DEPTH (FIFO_DEPTH),
    .BAUD_DIV   (BAUD_DIV)
  ) u_uart_tx (
    .clk        (clk),
    .rst_n      (rst_n),
    .i_push     (uart_push),
    .i_data     (i_mem_data[7:0]),
    .o_full     (uart_full),
    .o_empty    (uart_empty),
    .o_busy     (uart_busy),
    .o_overflow (uart_ovf),
    .i_clr_ovf  (uart_clr_ovf),
    .o_tx       (o_uart_tx)
  );

endmodule

// File: tb/tb_data_bus.sv
// tb_data_bus: directed checks of RAM, MMIO registers and the UART path.
module tb_data_bus;

  localparam int RAM_WORDS  = 1024;
  localparam int FIFO_DEPTH = 4;
  localparam int BAUD_DIV   = 4;

  localparam logic [29:0] A_LED   = 30'h2000_0000;
  localparam logic [29:0] A_CYCLE = 30'h2000_0001;
  localparam logic [29:0] A_UDATA = 30'h2000_0002;
  localparam logic [29:0] A_STAT  = 30'h2000_0003;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [29:0] i_mem_addr;
  logic [31:0] i_mem_data;
  logic        i_mem_we;
  logic [3:0]  i_mem_mask;
  logic [31:0] o_mem_data;
  logic        o_uart_tx;
  logic [7:0]  o_leds;

  int checks = 0;
  int errors = 0;
  logic [7:0] rx_q[$];
  logic [7:0] rx_byte;

  always #5 clk = ~clk;

  data_bus #(
    .RAM_WORDS  (RAM_WORDS),
    .FIFO_DEPTH (FIFO_DEPTH),
    .BAUD_DIV   (BAUD_DIV)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .i_mem_addr (i_mem_addr),
    .i_mem_data (i_mem_data),
    .i_mem_we   (i_mem_we),
    .i_mem_mask (i_mem_mask),
    .o_mem_data (o_mem_data),
    .o_uart_tx  (o_uart_tx),
    .o_leds     (o_leds)
  );

  // Serial receiver: samples mid-bit, BAUD_DIV cycles per bit.
  initial begin
    forever begin
      @(negedge clk);
      if (rst_n === 1'b1 && o_uart_tx === 1'b0) begin
        repeat (BAUD_DIV / 2) @(negedge clk);
        for (int k = 0; k < 8; k++) begin
          repeat (BAUD_DIV) @(negedge clk);
          rx_byte[k] = o_uart_tx;
        end
        repeat (BAUD_DIV) @(negedge clk);
        rx_q.push_back(rx_byte);
      end
    end
  end

  // Present one access for one clock; on return o_mem_data holds its result.
  task automatic bus(input logic [29:0] addr, input logic [31:0] data,
                     input logic we, input logic [3:0] mask);
    i_mem_addr = addr;
    i_mem_data = data;
    i_mem_we   = we;
    i_mem_mask = mask;
    @(negedge clk);
    i_mem_addr = '0;
    i_mem_data = '0;
    i_mem_we   = 1'b0;
    i_mem_mask = '0;
  endtask

  task automatic ld(input logic [29:0] addr);
    bus(addr, 32'h0, 1'b0, 4'h0);
  endtask

  task automatic st(input logic [29:0] addr, input logic [31:0] data, input logic [3:0] mask);
    bus(addr, data, 1'b1, mask);
  endtask

  task automatic test_reset();
    rst_n      = 1'b0;
    i_mem_addr = '0;
    i_mem_data = '0;
    i_mem_we   = 1'b0;
    i_mem_mask = '0;
    repeat (3) @(negedge clk);
    checks++; if (o_mem_data !== 32'h0) begin errors++; $display("FAIL reset_mem_data: got %h expected 00000000", o_mem_data); end
    checks++; if (o_uart_tx !== 1'b1) begin errors++; $display("FAIL reset_uart_tx: got %b expected 1", o_uart_tx); end
    checks++; if (o_leds !== 8'h00) begin errors++; $display("FAIL reset_leds: got %h expected 00", o_leds); end
    rst_n = 1'b1;
    @(negedge clk);
    ld(A_STAT);
    checks++; if (o_mem_data !== 32'h2) begin errors++; $display("FAIL reset_stat: got %h expected 00000002", o_mem_data); end
    ld(A_UDATA);
    checks++; if (o_mem_data !== 32'h0) begin errors++; $display("FAIL uart_data_reads_zero: got %h expected 00000000", o_mem_data); end
  endtask

  task automatic test_leds();
    st(A_LED, 32'h1234_56C3, 4'b0001);
    checks++; if (o_leds !== 8'hC3) begin errors++; $display("FAIL led_write: got %h expected c3", o_leds); end
    ld(A_LED);
    checks++; if (o_mem_data !== 32'h0000_00C3) begin errors++; $display("FAIL led_read: got %h expected 000000c3", o_mem_data); end
    st(A_LED, 32'hFFFF_FF00, 4'b1110);
    checks++; if (o_leds !== 8'hC3) begin errors++; $display("FAIL led_lane0_off: got %h expected c3", o_leds); end
  endtask

  task automatic test_ram_mask();
    st(30'd4, 32'h1122_3344, 4'hF);
    st(30'd4, 32'hAABB_CCDD, 4'b0101);
    checks++; if (o_mem_data !== 32'h1122_3344) begin errors++; $display("FAIL store_prewrite: got %h expected 11223344", o_mem_data); end
    ld(30'd4);
    checks++; if (o_mem_data !== 32'h11BB_33DD) begin errors++; $display("FAIL ram_mask_0101: got %h expected 11bb33dd", o_mem_data); end
    st(30'd5, 32'h1122_3344, 4'hF);
    st(30'd5, 32'hAABB_CCDD, 4'b0100);
    ld(30'd5);
    checks++; if (o_mem_data !== 32'h11BB_3344) begin errors++; $display("FAIL ram_mask_0100: got %h expected 11bb3344", o_mem_data); end
  endtask

  task automatic test_wrap_raw();
    st(30'd0, 32'h5, 4'hF);
    ld(30'd1024);
    checks++; if (o_mem_data !== 32'h5) begin errors++; $display("FAIL ram_wrap: got %h expected 00000005", o_mem_data); end
    st(30'd0, 32'h9, 4'hF);
    checks++; if (o_mem_data !== 32'h5) begin errors++; $display("FAIL ram_raw_old: got %h expected 00000005", o_mem_data); end
    ld(30'd0);
    checks++; if (o_mem_data !== 32'h9) begin errors++; $display("FAIL ram_raw_new: got %h expected 00000009", o_mem_data); end
  endtask

  task automatic test_cycle();
    st(A_CYCLE, 32'hFFFF_FFFE, 4'hF);
    ld(A_CYCLE);
    checks++; if (o_mem_data !== 32'hFFFF_FFFF) begin errors++; $display("FAIL cycle_0: got %h expected ffffffff", o_mem_data); end
    ld(A_CYCLE);
    checks++; if (o_mem_data !== 32'h0) begin errors++; $display("FAIL cycle_wrap: got %h expected 00000000", o_mem_data); end
    ld(A_CYCLE);
    checks++; if (o_mem_data !== 32'h1) begin errors++; $display("FAIL cycle_2: got %h expected 00000001", o_mem_data); end
    // Counter holds 1 here; loading lane 0 only keeps the upper lanes.
    st(A_CYCLE, 32'h1234_5678, 4'b0001);
    ld(A_CYCLE);
    checks++; if (o_mem_data !== 32'h0000_0079) begin errors++; $display("FAIL cycle_masked: got %h expected 00000079", o_mem_data); end
  endtask

  task automatic test_uart_frame();
    logic [7:0] frame;
    logic       exp_tx;
    logic [31:0] exp_stat;
    frame = 8'hA5;
    rx_q.delete();
    st(A_UDATA, 32'h0000_00A5, 4'b0001);
    checks++; if (o_uart_tx !== 1'b1) begin errors++; $display("FAIL frame_pre_start: got %b expected 1", o_uart_tx); end
    for (int i = 0; i < 10 * BAUD_DIV; i++) begin
      ld(A_STAT);
      if (i < BAUD_DIV) exp_tx = 1'b0;
      else if (i < 9 * BAUD_DIV) exp_tx = frame[(i - BAUD_DIV) / BAUD_DIV];
      else exp_tx = 1'b1;
      exp_stat = (i == 0) ? 32'h0 : 32'h6;
      checks++; if (o_uart_tx !== exp_tx) begin errors++; $display("FAIL frame_tx[%0d]: got %b expected %b", i, o_uart_tx, exp_tx); end
      checks++; if (o_mem_data !== exp_stat) begin errors++; $display("FAIL frame_stat[%0d]: got %h expected %h", i, o_mem_data, exp_stat); end
    end
    repeat (4) ld(A_STAT);
    checks++; if (o_mem_data !== 32'h2) begin errors++; $display("FAIL frame_idle_stat: got %h expected 00000002", o_mem_data); end
    checks++; if (rx_q.size() != 1) begin errors++; $display("FAIL frame_rx_count: got %0d expected 1", rx_q.size()); end
    else begin
      checks++; if (rx_q[0] !== 8'hA5) begin errors++; $display("FAIL frame_rx_byte: got %h expected a5", rx_q[0]); end
    end
  endtask

  task automatic test_overflow();
    bit done;
    rx_q.delete();
    for (int b = 0; b < FIFO_DEPTH + 2; b++) st(A_UDATA, 32'h11 + b, 4'b0001);
    ld(A_STAT);
    checks++; if (o_mem_data !== 32'hD) begin errors++; $display("FAIL ovf_stat: got %h expected 0000000d", o_mem_data); end
    st(A_STAT, 32'h8, 4'b0001);
    ld(A_STAT);
    checks++; if (o_mem_data !== 32'h5) begin errors++; $display("FAIL ovf_clear: got %h expected 00000005", o_mem_data); end
    done = 1'b0;
    for (int n = 0; n < 600 && !done; n++) begin
      ld(A_STAT);
      if (o_mem_data === 32'h2 && rx_q.size() >= FIFO_DEPTH + 1) done = 1'b1;
    end
    checks++; if (!done) begin errors++; $display("FAIL ovf_drain_timeout: got %0d bytes expected %0d", rx_q.size(), FIFO_DEPTH + 1); end
    repeat (60) @(negedge clk);
    checks++; if (rx_q.size() != FIFO_DEPTH + 1) begin errors++; $display("FAIL ovf_rx_count: got %0d expected %0d", rx_q.size(), FIFO_DEPTH + 1); end
    for (int b = 0; b < FIFO_DEPTH + 1 && b < rx_q.size(); b++) begin
      checks++; if (rx_q[b] !== 8'(8'h11 + b)) begin errors++; $display("FAIL ovf_rx_byte[%0d]: got %h expected %h", b, rx_q[b], 8'(8'h11 + b)); end
    end
  endtask

  task automatic test_reset_midframe();
    st(A_LED, 32'hFF, 4'b0001);
    st(A_UDATA, 32'h3C, 4'b0001);
    repeat (BAUD_DIV + 1) ld(A_LED);
    checks++; if (o_uart_tx !== 1'b0) begin errors++; $display("FAIL midframe_pre_tx: got %b expected 0", o_uart_tx); end
    checks++; if (o_mem_data !== 32'hFF) begin errors++; $display("FAIL midframe_pre_data: got %h expected 000000ff", o_mem_data); end
    #2 rst_n = 1'b0;
    #1;
    checks++; if (o_uart_tx !== 1'b1) begin errors++; $display("FAIL midframe_tx: got %b expected 1", o_uart_tx); end
    checks++; if (o_leds !== 8'h00) begin errors++; $display("FAIL midframe_leds: got %h expected 00", o_leds); end
    checks++; if (o_mem_data !== 32'h0) begin errors++; $display("FAIL midframe_mem_data: got %h expected 00000000", o_mem_data); end
    @(negedge clk);
    rst_n = 1'b1;
    repeat (60) @(negedge clk);
    rx_q.delete();
    repeat (60) @(negedge clk);
    checks++; if (rx_q.size() != 0) begin errors++; $display("FAIL midframe_no_resend: got %0d bytes expected 0", rx_q.size()); end
    ld(A_STAT);
    checks++; if (o_mem_data !== 32'h2) begin errors++; $display("FAIL midframe_stat: got %h expected 00000002", o_mem_data); end
  endtask

  initial begin
    test_reset();
    test_leds();
    test_ram_mask();
    test_wrap_raw();
    test_cycle();
    test_uart_frame();
    test_overflow();
    test_reset_midframe();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, checks %0d errors %0d", checks, errors);
    $fatal(1, "watchdog expired");
  end

endmodule
